// File: rtl/dm_store_merge.sv
// Store-side data memory port: writes sw directly and performs a read-modify-write
// for sb/sh into a word-wide RAM without byte enables. Flags misaligned/illegal stores.
module dm_store_merge #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       addr,
    input  logic [1:0]        op,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SB = 2'b01;
    localparam logic [1:0] OP_SH = 2'b10;
    localparam logic [1:0] OP_IL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MG,
        S_WR,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        op_q, op_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       merged;
    logic              bad_req;

    // Upper address bits wrap modulo the RAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign bad_req = (op == OP_IL)
                  || ((op == OP_SW) && (addr[1:0] != 2'b00))
                  || ((op == OP_SH) && addr[0]);

    // Replace only the addressed lane; data_q still holds the latched store data here.
    always_comb begin
        merged = mem_rdata;
        if (op_q == OP_SB) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else if (op_q == OP_SH) begin
            merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = addr[ADDR_W+1:2];
                    lane_d = addr[1:0];
                    op_d   = op;
                    data_d = wdata;
                    if (bad_req) begin
                        state_d = S_ERR;
                    end else if (op == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_MG;
            S_MG: begin
                data_d  = merged;
                state_d = S_WR;
            end
            S_WR:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Strobes decode straight from the state register so they cannot glitch.
    assign req_ready = (state_q == S_IDLE);
    assign mem_we    = (state_q == S_WR);
    assign done      = (state_q == S_WR);
    assign err       = (state_q == S_ERR);
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_dm_store_merge.sv
// Directed bench for dm_store_merge with a synchronous-read RAM model and a
// negedge monitor that records write strobes and done pulses.
module tb_dm_store_merge;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       addr;
    logic [1:0]        op;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              done;
    logic              err;

    dm_store_merge #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .op        (op),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read, write-port shared with a bench preload port.
    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;
    logic [31:0]       rdata_q = '0;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        rdata_q <= ram[mem_addr];
    end
    assign mem_rdata = rdata_q;

    int we_count = 0;
    int cyc = 0;
    int done_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) we_count++;
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a[ADDR_W-1:0];
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Present one request while idle; returns #1 after the accepting edge.
    task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_we"},    {31'b0, mem_we},    32'd0);
        check({tag, "_done"},  {31'b0, done},      32'd0);
        check({tag, "_err"},   {31'b0, err},       32'd0);
    endtask

    logic [1:0]  err_op   [3] = '{2'b10, 2'b00, 2'b11};
    logic [31:0] err_addr [3] = '{32'h5, 32'h2, 32'h0};
    logic [31:0] b2b_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int          we_snap;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        addr      = '0;
        op        = '0;
        wdata     = '0;
        repeat (3) step();
        check_idle("rst");
        check("rst_maddr", 32'(mem_addr), 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // sw: write in the cycle after accept, ready low for one cycle
        accept(2'b00, 32'h0000_0008, 32'hDEADBEEF);
        check("sw_we",    {31'b0, mem_we},    32'd1);
        check("sw_done",  {31'b0, done},      32'd1);
        check("sw_ready", {31'b0, req_ready}, 32'd0);
        check("sw_maddr", 32'(mem_addr),      32'd2);
        check("sw_wdata", mem_wdata,          32'hDEADBEEF);
        step();
        check_idle("sw_after");
        check("sw_ram", ram[2], 32'hDEADBEEF);

        // address wrap: bits above ADDR_W+1 ignored
        accept(2'b00, 32'h8000_0404, 32'h0BADF00D);
        check("wrap_maddr", 32'(mem_addr), 32'd257);
        step();

        // sb to lane 2 of word 3
        preload(3, 32'h11223344);
        accept(2'b01, 32'h0000_000E, 32'h0000_00AB);
        check("sb_c1_we",    {31'b0, mem_we},    32'd0);
        check("sb_c1_ready", {31'b0, req_ready}, 32'd0);
        check("sb_c1_maddr", 32'(mem_addr),      32'd3);
        step();
        check("sb_c2_we",    {31'b0, mem_we},    32'd0);
        check("sb_c2_ready", {31'b0, req_ready}, 32'd0);
        step();
        check("sb_c3_we",    {31'b0, mem_we},    32'd1);
        check("sb_c3_done",  {31'b0, done},      32'd1);
        check("sb_c3_ready", {31'b0, req_ready}, 32'd0);
        check("sb_c3_maddr", 32'(mem_addr),      32'd3);
        check("sb_c3_wdata", mem_wdata,          32'h11AB3344);
        step();
        check_idle("sb_after");
        check("sb_ram", ram[3], 32'h11AB3344);

        // sh upper then lower half of word 1
        preload(1, 32'hCAFEF00D);
        accept(2'b10, 32'h0000_0006, 32'hFFFF_1234);
        step();
        step();
        check("shu_we",    {31'b0, mem_we}, 32'd1);
        check("shu_wdata", mem_wdata,       32'h1234F00D);
        step();
        check("shu_ram", ram[1], 32'h1234F00D);
        preload(1, 32'hCAFEF00D);
        accept(2'b10, 32'h0000_0004, 32'hFFFF_1234);
        step();
        step();
        check("shl_we",    {31'b0, mem_we}, 32'd1);
        check("shl_wdata", mem_wdata,       32'hCAFE1234);
        step();
        check("shl_ram", ram[1], 32'hCAFE1234);

        // error cases: misaligned sh, misaligned sw, illegal op
        preload(0, 32'h5A5A5A5A);
        preload(1, 32'hCAFEF00D);
        we_snap = we_count;
        for (int i = 0; i < 3; i++) begin
            accept(err_op[i], err_addr[i], 32'hFFFF_FFFF);
            check($sformatf("err%0d_err", i),   {31'b0, err},       32'd1);
            check($sformatf("err%0d_we", i),    {31'b0, mem_we},    32'd0);
            check($sformatf("err%0d_ready", i), {31'b0, req_ready}, 32'd0);
            step();
            check_idle($sformatf("err%0d_after", i));
        end
        step();
        check("err_we_count", 32'(we_count - we_snap), 32'd0);
        check("err_ram0", ram[0], 32'h5A5A5A5A);
        check("err_ram1", ram[1], 32'hCAFEF00D);

        // back-to-back sb to word 0, req_valid held high
        preload(0, 32'h0000_0000);
        done_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            op        = 2'b01;
            addr      = 32'(i);
            wdata     = b2b_data[i];
            for (int k = 0; k < 8 && req_ready !== 1'b1; k++) @(negedge clk);
            check($sformatf("b2b%0d_ready_seen", i), {31'b0, req_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        repeat (5) step();
        check("b2b_done_count", 32'(done_cyc.size()), 32'd4);
        if (done_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check($sformatf("b2b_spacing%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd4);
        end
        check("b2b_ram", ram[0], 32'h44332211);

        // reset while in MG: nothing committed
        preload(5, 32'hA5A5A5A5);
        we_snap = we_count;
        accept(2'b01, 32'h0000_0014, 32'h0000_00FF);
        step();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle("rstmg");
        check("rstmg_mwdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step();
        check("rstmg_we_count", 32'(we_count - we_snap), 32'd0);
        check("rstmg_ram", ram[5], 32'hA5A5A5A5);

        // simultaneous reset and request: request dropped
        we_snap = we_count;
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        op        = 2'b00;
        addr      = 32'h0000_0020;
        wdata     = 32'h1234_5678;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        repeat (3) step();
        check_idle("rstreq");
        check("rstreq_we_count", 32'(we_count - we_snap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_store_merge.md
Name: dm_store_merge

Overview:
- Store-side companion to the load extender on the data memory path.
- Takes MEM-stage store requests (sw/sh/sb) and writes them into a word-wide data RAM that has no byte enables.
- Full-word stores are written directly. Sub-word stores use a read-modify-write sequence.
- Holds the pipeline via req_ready while busy, and flags misaligned or illegal stores.

Parameters:
- ADDR_W, 10, number of word-address bits driven to the data RAM (RAM depth = 2^ADDR_W words).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  block idle and able to accept a request; pipeline stalls when low
- addr  input  32  byte address of the store
- op  input  2  00 = sw, 01 = sb, 10 = sh, 11 = illegal
- wdata  input  32  store data (sb uses [7:0], sh uses [15:0])
- mem_addr  output  ADDR_W  word address to the RAM, equal to the latched addr[ADDR_W+1:2]
- mem_we  output  1  RAM write enable
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data; synchronous, valid one cycle after mem_addr is presented
- done  output  1  one-cycle pulse, asserted in the cycle the RAM write occurs
- err  output  1  one-cycle pulse: misaligned store or illegal op; nothing is written

Behaviour:
- Reset values: state = IDLE, req_ready = 1, mem_we = 0, done = 0, err = 0, mem_wdata = 0, mem_addr = 0, latched registers = 0.
- Byte lane convention: little-endian. Lane A[1:0] = 00 is bits [7:0], 11 is bits [31:24]. Halfword A[1] = 0 is bits [15:0], 1 is bits [31:16].
- Accept condition: req_valid && req_ready on a clock edge. On accept, latch addr, op and wdata. Inputs are ignored while req_ready = 0.
- Alignment check at accept time:
  - sw requires addr[1:0] == 00.
  - sh requires addr[0] == 0.
  - sb is always aligned.
  - op 11 is illegal.
  - Misaligned or illegal → next state ERR.
- States:
  - IDLE: req_ready = 1.
    - On accept with an aligned sw → WR.
    - On accept with an aligned sb/sh → RD.
    - On accept with a bad request → ERR.
  - RD: mem_addr presents the word address; the RAM read is in flight. → MG.
  - MG: mem_rdata is valid. Register merged = mem_rdata with the selected byte or half lane replaced by wdata[7:0] or wdata[15:0]. All other lanes are unchanged. → WR.
  - WR: mem_we = 1, done = 1.
    - mem_wdata = latched wdata for sw, or the merged word for sb/sh.
    - → IDLE.
  - ERR: err = 1, mem_we = 0. → IDLE.
- req_ready = 1 only in IDLE. mem_we, done and err are decoded from the state register only, so they are glitch-free.
- Latency from the accept edge:
  - sw: write and done in the next cycle (occupancy 2 cycles including IDLE).
  - sb/sh: write and done 3 cycles after accept.
  - Error: err 1 cycle after accept.
- Back-to-back requests: a new request is accepted in the IDLE cycle following WR or ERR. Peak throughput is one sw every 2 cycles and one sb/sh every 4 cycles.
- mem_addr holds the latched word address in RD, MG and WR. It is don't-care in IDLE and ERR.
- Address bits above ADDR_W+1 are ignored (wrap-around modulo the RAM size).
- Reset mid-operation (any state): next edge goes to IDLE. No write is issued after the reset edge and no partial merge is committed. done and err are 0.
- Simultaneous reset and req_valid: reset wins and the request is dropped.

Test Plan:
- Reset, then sw addr=0x0000_0008, wdata=0xDEADBEEF → one cycle later: mem_we=1, mem_addr=2, mem_wdata=0xDEADBEEF, done=1. req_ready=0 for exactly 1 cycle.
- RAM word 3 = 0x11223344; sb addr=0x0000_000E, wdata=0x0000_00AB → mem_we=1 exactly 3 cycles after accept with mem_wdata=0x11AB3344; done=1 in the same cycle; req_ready low for 3 cycles.
- RAM word 1 = 0xCAFEF00D; sh addr=0x0000_0006, wdata=0xFFFF_1234 → write 0x1234F00D to word 1. Repeat with addr=0x4 → write 0xCAFE1234.
- Misaligned sh addr=0x5, misaligned sw addr=0x2, and op=11 at addr=0x0 → each gives err=1 for 1 cycle after accept, mem_we never asserted, RAM contents unchanged, req_ready=1 again on the following cycle.
- Back-to-back sb to bytes 0..3 of word 0 (init 0x00000000) with wdata 0x11, 0x22, 0x33, 0x44, req_valid held high → final RAM word 0 = 0x44332211, 4 done pulses spaced 4 cycles apart.
- sb accepted, then reset asserted in MG → no mem_we after the reset edge, RAM word unchanged, state IDLE, req_ready=1, done=0, err=0.
